bomb_defuse_controller: RTL and testbench

- Downstream consumer of the maze stage's `wire_to_cut` target.
- Runs the bomb countdown, watches the three physical cut-wire switches, counts strikes and declares DEFUSED or EXPLODED.
- Its outputs drive the 7-segment timer and status LEDs and gate the end-of-game screen.
- Sits beside `show_colour_code` and shares the same cut-wire switches.

---
 rtl/bomb_defuse_controller.sv | 127 ++++++++++++
 tb/tb_bomb_defuse_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_defuse_controller.sv
// rtl/bomb_defuse_controller.sv - bomb countdown, cut-wire strike tracking and defuse/explode decision
module bomb_defuse_controller #(
  parameter int CLK_HZ       = 100000000,
  parameter int TIME_LIMIT_S = 60,
  parameter int PENALTY_S    = 10,
  parameter int MAX_STRIKES  = 3
) (
  input  logic       basys_clock,
  input  logic       reset,
  input  logic       arm,
  input  logic [2:0] wire_to_cut,
  input  logic [2:0] cut_sw,
  output logic [1:0] state,
  output logic [6:0] seconds_left,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic [1:0] strikes,
  output logic       sec_pulse,
  output logic       defused,
  output logic       exploded
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_ARMED    = 2'b01,
    S_DEFUSED  = 2'b10,
    S_EXPLODED = 2'b11
  } state_t;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  state_t        cur_state, nxt_state;
  logic [PW-1:0] prescaler, prescaler_nxt;
  logic [6:0]    secs_q, secs_nxt;
  logic [1:0]    strikes_q, strikes_nxt;
  logic [2:0]    cut_sync1, cut_sync2, cut_prev;
  logic          arm_prev;

  logic [2:0] rise;
  logic       arm_rise;
  logic       tick;
  logic       correct_cut;
  logic [1:0] new_strikes;
  logic [7:0] penalty;
  logic [7:0] secs_ext;
  logic [6:0] secs_after_penalty;

  assign rise        = cut_sync2 & ~cut_prev;
  assign arm_rise    = arm & ~arm_prev;
  assign tick        = (cur_state == S_ARMED) && (prescaler == PW'(CLK_HZ - 1));
  assign correct_cut = (wire_to_cut != 3'b000) && $onehot(rise) && (rise == wire_to_cut);

  // Penalty arithmetic is 8 bits wide so an oversized penalty clamps to zero instead of wrapping.
  assign penalty            = 8'(PENALTY_S) + {7'd0, tick};
  assign secs_ext           = {1'b0, secs_q};
  assign secs_after_penalty = (secs_ext > penalty) ? 7'(secs_ext - penalty) : 7'd0;
  assign new_strikes        = strikes_q + 2'd1;

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      cur_state <= S_IDLE;
      prescaler <= '0;
      secs_q    <= 7'(TIME_LIMIT_S);
      strikes_q <= 2'd0;
      cut_sync1 <= 3'b000;
      cut_sync2 <= 3'b000;
      cut_prev  <= 3'b000;
      arm_prev  <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      prescaler <= prescaler_nxt;
      secs_q    <= secs_nxt;
      strikes_q <= strikes_nxt;
      cut_sync1 <= cut_sw;
      cut_sync2 <= cut_sync1;
      cut_prev  <= cut_sync2;
      arm_prev  <= arm;
    end
  end

  always_comb begin
    nxt_state     = cur_state;
    prescaler_nxt = prescaler;
    secs_nxt      = secs_q;
    strikes_nxt   = strikes_q;
    case (cur_state)
      S_IDLE: begin
        if (arm_rise) begin
          nxt_state     = S_ARMED;
          prescaler_nxt = '0;
          secs_nxt      = 7'(TIME_LIMIT_S);
          strikes_nxt   = 2'd0;
        end
      end
      S_ARMED: begin
        prescaler_nxt = tick ? '0 : prescaler + PW'(1);
        // A correct cut wins over a same-cycle tick, freezing the displayed time.
        if (correct_cut) begin
          nxt_state = S_DEFUSED;
        end else if (rise != 3'b000) begin
          strikes_nxt = new_strikes;
          secs_nxt    = secs_after_penalty;
          if ((new_strikes == 2'(MAX_STRIKES)) || (secs_after_penalty == 7'd0)) begin
            nxt_state = S_EXPLODED;
          end
        end else if (tick) begin
          secs_nxt = secs_q - 7'd1;
          if (secs_q == 7'd1) begin
            nxt_state = S_EXPLODED;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign state        = cur_state;
  assign seconds_left = secs_q;
  assign secs_tens    = 4'(secs_q / 7'd10);
  assign secs_ones    = 4'(secs_q % 7'd10);
  assign strikes      = strikes_q;
  assign sec_pulse    = tick;
  assign defused      = (cur_state == S_DEFUSED);
  assign exploded     = (cur_state == S_EXPLODED);

endmodule

// File: tb/tb_bomb_defuse_controller.sv
// tb/tb_bomb_defuse_controller.sv - randomized scoreboard bench for bomb_defuse_controller
module tb_bomb_defuse_controller;

  localparam int CLK_HZ = 10;
  localparam int TL     = 60;
  localparam int PEN    = 10;
  localparam int MAXS   = 3;
  localparam int HIST   = 16384;

  logic       basys_clock = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic [2:0] wire_to_cut = 3'b000;
  logic [2:0] cut_sw = 3'b000;
  logic [1:0] state;
  logic [6:0] seconds_left;
  logic [3:0] secs_tens, secs_ones;
  logic [1:0] strikes;
  logic       sec_pulse, defused, exploded;

  bomb_defuse_controller #(
    .CLK_HZ(CLK_HZ), .TIME_LIMIT_S(TL), .PENALTY_S(PEN), .MAX_STRIKES(MAXS)
  ) dut (
    .basys_clock(basys_clock), .reset(reset), .arm(arm),
    .wire_to_cut(wire_to_cut), .cut_sw(cut_sw), .state(state),
    .seconds_left(seconds_left), .secs_tens(secs_tens), .secs_ones(secs_ones),
    .strikes(strikes), .sec_pulse(sec_pulse), .defused(defused), .exploded(exploded)
  );

  always #5 basys_clock = ~basys_clock;

  int cyc = 0;
  always @(posedge basys_clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int st;
    int secs;
    int strk;
    int pulse;
  } ev_t;

  ev_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Game model: phase 0 idle, 1 armed, 2 defused, 3 exploded.
  int m_ph = 0, m_secs = TL, m_strk = 0, m_arm_edge = 0;
  int p_ph = 0, p_secs = TL, p_strk = 0;
  logic [2:0] cuth [HIST];
  logic       armh [HIST];
  logic       cur_arm = 1'b0;
  logic [2:0] cur_cut = 3'b000;
  logic [2:0] cur_wire = 3'b000;

  // Inputs of interval m are known; emit the record for interval m, then advance over edge m+1.
  task automatic model_step(input int m, input logic r);
    int n;
    int pulse;
    int dec;
    bit tick;
    logic [2:0] rise;
    logic arise;
    n = m + 1;
    pulse = (m_ph == 1 && ((n - m_arm_edge) % CLK_HZ) == 0) ? 1 : 0;
    if (m_ph != p_ph || m_secs != p_secs || m_strk != p_strk || pulse == 1)
      q.push_back('{cyc: m, st: m_ph, secs: m_secs, strk: m_strk, pulse: pulse});
    p_ph = m_ph; p_secs = m_secs; p_strk = m_strk;
    if (r) begin
      m_ph = 0; m_secs = TL; m_strk = 0;
      cuth[m] = 3'b000; cuth[m-1] = 3'b000; cuth[m-2] = 3'b000;
      armh[m] = 1'b0;
    end else begin
      // A cut change driven during interval k is acted on at edge k+3.
      rise  = cuth[n-3] & ~cuth[n-4];
      arise = armh[n-1] & ~armh[n-2];
      if (m_ph == 0) begin
        if (arise) begin
          m_ph = 1; m_arm_edge = n; m_secs = TL; m_strk = 0;
        end
      end else if (m_ph == 1) begin
        tick = ((n - m_arm_edge) % CLK_HZ) == 0;
        if (rise != 0 && $countones(rise) == 1 && rise == cur_wire) begin
          m_ph = 2;
        end else if (rise != 0) begin
          m_strk++;
          dec = PEN + (tick ? 1 : 0);
          m_secs = (m_secs > dec) ? m_secs - dec : 0;
          if (m_strk == MAXS || m_secs == 0) m_ph = 3;
        end else if (tick) begin
          m_secs--;
          if (m_secs == 0) m_ph = 3;
        end
      end
    end
  endtask

  task automatic step(input logic r);
    arm = cur_arm; cut_sw = cur_cut; wire_to_cut = cur_wire; reset = r;
    armh[cyc] = cur_arm; cuth[cyc] = cur_cut;
    model_step(cyc, r);
    @(posedge basys_clock); #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic arm_pulse();
    cur_arm = 1'b1; step(1'b0);
    cur_arm = 1'b0; step(1'b0);
  endtask

  task automatic new_game(input logic [2:0] w, input logic [2:0] c);
    cur_arm = 1'b0; cur_cut = c; cur_wire = w;
    step(1'b1);
    wait_n(5);
  endtask

  task automatic run_until_edge(input int edge_ofs);
    while (cyc + 3 < m_arm_edge + edge_ofs) step(1'b0);
  endtask

  bit mon_en = 0;
  int l_st = 0, l_secs = TL, l_strk = 0;

  always @(negedge basys_clock) begin
    if (mon_en) begin
      ev_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (int'(state) != l_st || int'(seconds_left) != l_secs || int'(strikes) != l_strk || sec_pulse) begin
        if (q.size() == 0) begin
          chk("unexpected_event_qsize", 0, 1);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("state", int'(state), e.st);
          chk("seconds_left", int'(seconds_left), e.secs);
          chk("strikes", int'(strikes), e.strk);
          chk("sec_pulse", int'(sec_pulse), e.pulse);
          chk("secs_tens", int'(secs_tens), e.secs / 10);
          chk("secs_ones", int'(secs_ones), e.secs % 10);
          chk("defused", int'(defused), (e.st == 2) ? 1 : 0);
          chk("exploded", int'(exploded), (e.st == 3) ? 1 : 0);
        end
      end
      l_st = int'(state); l_secs = int'(seconds_left); l_strk = int'(strikes);
    end
  end

  initial begin
    for (int i = 0; i < HIST; i++) begin
      cuth[i] = 3'b000;
      armh[i] = 1'b0;
    end
    repeat (3) @(posedge basys_clock);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_seconds_left", int'(seconds_left), TL);
    chk("rst_strikes", int'(strikes), 0);
    chk("rst_sec_pulse", int'(sec_pulse), 0);
    chk("rst_defused", int'(defused), 0);
    chk("rst_exploded", int'(exploded), 0);
    chk("rst_tens", int'(secs_tens), TL / 10);
    chk("rst_ones", int'(secs_ones), TL % 10);
    mon_en = 1;

    // Countdown runs out with no cuts; arm and cuts afterwards are ignored.
    new_game(3'b000, 3'b000);
    arm_pulse();
    wait_n(610);
    arm_pulse();
    cur_cut = 3'b111; wait_n(10);

    // Correct cut defuses; later activity changes nothing.
    new_game(3'b010, 3'b000);
    arm_pulse();
    wait_n(37);
    cur_cut = 3'b010; wait_n(10);
    cur_cut = 3'b011; wait_n(5);
    arm_pulse();
    cur_cut = 3'b000; wait_n(20);

    // Three wrong cuts, the last a re-cut of a wire toggled low.
    new_game(3'b100, 3'b000);
    arm_pulse();
    wait_n(23);
    cur_cut = 3'b001; wait_n(30);
    cur_cut = 3'b011; wait_n(30);
    cur_cut = 3'b010; wait_n(10);
    cur_cut = 3'b011; wait_n(20);

    // Penalty saturates at zero with seven seconds left.
    new_game(3'b001, 3'b000);
    arm_pulse();
    run_until_edge(535);
    cur_cut = 3'b010; wait_n(20);

    // Wrong cut landing on a tick with fifteen seconds left.
    new_game(3'b100, 3'b000);
    arm_pulse();
    run_until_edge(460);
    cur_cut = 3'b001; wait_n(20);

    // Two-bit simultaneous cut, then a cut while the target is unknown.
    new_game(3'b010, 3'b000);
    arm_pulse();
    wait_n(15);
    cur_cut = 3'b011; wait_n(10);
    cur_wire = 3'b000;
    cur_cut = 3'b111; wait_n(15);

    // Wires cut before arming never count.
    new_game(3'b010, 3'b111);
    arm_pulse();
    wait_n(40);
    cur_cut = 3'b000; wait_n(5);
    cur_cut = 3'b010; wait_n(10);

    // Reset mid-game after a strike, then a clean restart.
    new_game(3'b100, 3'b000);
    arm_pulse();
    wait_n(50);
    cur_cut = 3'b001;
    run_until_edge(205);
    step(1'b1);
    cur_cut = 3'b000;
    wait_n(5);
    arm_pulse();
    wait_n(40);

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      int w;
      w = $urandom_range(0, 4);
      new_game((w == 0) ? 3'b000 : 3'(1 << $urandom_range(0, 2)), 3'($urandom_range(0, 7)));
      arm_pulse();
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 9))
          0:       arm_pulse();
          1:       if ($urandom_range(0, 3) == 0) step(1'b1);
          2, 3:    cur_cut = cur_cut ^ 3'($urandom_range(1, 7));
          default: cur_cut = cur_cut ^ 3'(1 << $urandom_range(0, 2));
        endcase
        wait_n($urandom_range(1, 25));
      end
    end

    cur_cut = 3'b000;
    step(1'b1);
    wait_n(10);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
